// File: rtl/gemm_pkg.sv
// Shared constants and the line-buffer entry type for the GEMM result path.
package gemm_pkg;

    localparam int FP16_LANES_PER_LINE = 16;
    localparam int RESULT_LINE_WIDTH   = 256;
    localparam int LANE_IDX_W          = $clog2(FP16_LANES_PER_LINE);

    typedef struct packed {
        logic                         last;
        logic [RESULT_LINE_WIDTH-1:0] data;
    } line_entry_t;

endpackage

// File: rtl/result_line_fifo.sv
// Synchronous line FIFO with first-word-fall-through output driven from registered storage.
module result_line_fifo
    import gemm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  line_entry_t   i_entry,
    input  logic          i_pop,
    output line_entry_t   o_entry,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_afull
);

    localparam int AW = $clog2(DEPTH);

    line_entry_t   mem_q [DEPTH];
    line_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = i_pop && (count_q != '0);
        // At full a push only lands when a pop frees the slot in the same cycle.
        push_ok  = i_push && ((count_q != CW'(DEPTH)) || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = i_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Storage is not reset; gating on occupancy keeps the output zero whenever empty.
    assign o_valid = (count_q != '0);
    assign o_entry = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_afull = (count_q >= CW'(DEPTH - 1));

endmodule

// File: rtl/result_line_packer.sv
// Packs FP16 results into 256-bit lines and queues them for the downstream consumer.
module result_line_packer
    import gemm_pkg::*;
#(
    parameter int LINE_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_tile_en,
    input  logic                         i_tile_done,
    input  logic [15:0]                  i_result_data,
    input  logic                         i_result_valid,
    output logic                         o_result_full,
    output logic                         o_result_afull,
    output logic [RESULT_LINE_WIDTH-1:0] o_line_data,
    output logic                         o_line_valid,
    output logic                         o_line_last,
    input  logic                         i_line_ready,
    output logic                         o_overflow,
    output logic [15:0]                  o_result_count,
    output logic [15:0]                  o_line_count
);

    localparam int CW = $clog2(LINE_DEPTH) + 1;

    logic [LANE_IDX_W-1:0]        lane_q, lane_d;
    logic [RESULT_LINE_WIDTH-1:0] partial_q, partial_d;
    logic [15:0]                  result_count_q, result_count_d;
    logic [15:0]                  line_count_q, line_count_d;
    logic                         overflow_q, overflow_d;

    logic [RESULT_LINE_WIDTH-1:0] wr_line;
    logic                         complete;
    logic                         filled;
    logic                         push;
    logic                         pop;
    line_entry_t                  entry;
    line_entry_t                  head;
    logic [CW-1:0]                fifo_count;

    assign pop = o_line_valid && i_line_ready;

    always_comb begin
        lane_d         = lane_q;
        partial_d      = partial_q;
        result_count_d = result_count_q;
        line_count_d   = line_count_q;
        overflow_d     = overflow_q;
        push           = 1'b0;
        entry          = '0;

        wr_line = partial_q;
        if (i_result_valid) begin
            wr_line[{lane_q, 4'b0000} +: 16] = i_result_data;
        end
        complete = i_result_valid && (lane_q == LANE_IDX_W'(FP16_LANES_PER_LINE - 1));
        filled   = i_result_valid || (lane_q != '0);

        if (i_tile_en) begin
            lane_d         = '0;
            partial_d      = '0;
            result_count_d = '0;
            line_count_d   = '0;
            overflow_d     = 1'b0;
        end else begin
            if (i_result_valid) begin
                result_count_d = result_count_q + 16'd1;
                lane_d         = lane_q + 1'b1;
                partial_d      = wr_line;
            end
            // A write and a flush in one cycle merge into a single push carrying last.
            if (complete || (i_tile_done && filled)) begin
                lane_d     = '0;
                partial_d  = '0;
                entry.data = wr_line;
                entry.last = i_tile_done;
                if ((fifo_count != CW'(LINE_DEPTH)) || pop) begin
                    push         = 1'b1;
                    line_count_d = line_count_q + 16'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lane_q         <= '0;
            partial_q      <= '0;
            result_count_q <= '0;
            line_count_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            lane_q         <= lane_d;
            partial_q      <= partial_d;
            result_count_q <= result_count_d;
            line_count_q   <= line_count_d;
            overflow_q     <= overflow_d;
        end
    end

    result_line_fifo #(
        .DEPTH (LINE_DEPTH),
        .CW    (CW)
    ) u_line_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_entry (entry),
        .i_pop   (pop),
        .o_entry (head),
        .o_valid (o_line_valid),
        .o_count (fifo_count),
        .o_full  (o_result_full),
        .o_afull (o_result_afull)
    );

    assign o_line_data    = head.data;
    assign o_line_last    = head.last;
    assign o_overflow     = overflow_q;
    assign o_result_count = result_count_q;
    assign o_line_count   = line_count_q;

endmodule

// File: tb/tb_result_line_packer.sv
// Directed bench for result_line_packer: queue-based reference model plus literal spot checks.
module tb_result_line_packer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tile_en = 1'b0;
    logic         tile_done = 1'b0;
    logic         r_valid = 1'b0;
    logic [15:0]  r_data = '0;
    logic         ready = 1'b0;

    logic         res_full, res_afull, line_valid, line_last, overflow;
    logic [255:0] line_data;
    logic [15:0]  result_count, line_count;

    int checks = 0;
    int failures = 0;

    result_line_packer #(.LINE_DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_tile_en      (tile_en),
        .i_tile_done    (tile_done),
        .i_result_data  (r_data),
        .i_result_valid (r_valid),
        .o_result_full  (res_full),
        .o_result_afull (res_afull),
        .o_line_data    (line_data),
        .o_line_valid   (line_valid),
        .o_line_last    (line_last),
        .i_line_ready   (ready),
        .o_overflow     (overflow),
        .o_result_count (result_count),
        .o_line_count   (line_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: lanes held as an array, line buffer as a queue of whole lines.
    typedef struct {
        logic [255:0] data;
        bit           last;
    } line_t;

    logic [15:0] m_lanes [16];
    int          m_nl = 0;
    logic [15:0] m_rc = '0;
    logic [15:0] m_lc = '0;
    bit          m_ovf = 1'b0;
    line_t       m_q [$];

    always @(posedge clk or posedge rst) begin : model
        bit    was_full;
        bit    do_pop;
        line_t ln;
        if (rst) begin
            m_q.delete();
            m_nl  = 0;
            m_rc  = '0;
            m_lc  = '0;
            m_ovf = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            do_pop   = (m_q.size() > 0) && ready;
            if (do_pop) void'(m_q.pop_front());
            if (tile_en) begin
                m_nl  = 0;
                m_rc  = '0;
                m_lc  = '0;
                m_ovf = 1'b0;
            end else begin
                if (r_valid) begin
                    m_lanes[m_nl] = r_data;
                    m_nl++;
                    m_rc++;
                end
                if (m_nl == 16 || (tile_done && m_nl > 0)) begin
                    ln.data = '0;
                    for (int k = 0; k < m_nl; k++) ln.data[16*k +: 16] = m_lanes[k];
                    ln.last = tile_done;
                    if (!was_full || do_pop) begin
                        m_q.push_back(ln);
                        m_lc++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_nl = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("line_valid", line_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("line_data", line_data, m_q[0].data);
            chk("line_last", line_last, m_q[0].last);
        end
        chk("result_count", result_count, m_rc);
        chk("line_count", line_count, m_lc);
        chk("overflow", overflow, m_ovf);
        chk("full", res_full, m_q.size() == DEPTH);
        chk("afull", res_afull, m_q.size() >= DEPTH - 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        r_valid = 1'b1;
        r_data  = d;
        step();
        r_valid = 1'b0;
    endtask

    task automatic pulse_en();
        tile_en = 1'b1;
        step();
        tile_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, line_valid, 0);
        chk({tag, "_last"}, line_last, 0);
        chk({tag, "_data"}, line_data, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_rcnt"}, result_count, 0);
        chk({tag, "_lcnt"}, line_count, 0);
        chk({tag, "_full"}, res_full, 0);
        chk({tag, "_afull"}, res_afull, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [255:0] exp_line;

        repeat (2) step();
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // One full line with ready held high.
        ready = 1'b1;
        pulse_en();
        for (int i = 0; i < 15; i++) wr(16'h3C00 + 16'(i));
        @(negedge clk);
        chk("l1_valid_before16", line_valid, 0);
        wr(16'h3C0F);
        @(negedge clk);
        chk("l1_valid", line_valid, 1);
        chk("l1_lane0", line_data[15:0], 16'h3C00);
        chk("l1_lane15", line_data[255:240], 16'h3C0F);
        chk("l1_last", line_last, 0);
        chk("l1_lcnt", line_count, 1);
        step();
        step();

        // Tile start beats a concurrent write; then partial flush.
        tile_en = 1'b1;
        r_valid = 1'b1;
        r_data  = 16'hFFFF;
        step();
        tile_en = 1'b0;
        r_valid = 1'b0;
        for (int i = 1; i <= 5; i++) wr(16'(i));
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        @(negedge clk);
        exp_line = '0;
        exp_line[79:0] = 80'h0005_0004_0003_0002_0001;
        chk("flush_data", line_data, exp_line);
        chk("flush_last", line_last, 1);
        chk("flush_rcnt", result_count, 5);
        step();
        step();

        // Fill the buffer with ready low, then overflow.
        ready = 1'b0;
        pulse_en();
        for (int i = 0; i < 47; i++) wr(16'h1000 + 16'(i));
        @(negedge clk);
        chk("afull_47", res_afull, 0);
        wr(16'h102F);
        @(negedge clk);
        chk("afull_48", res_afull, 1);
        chk("full_48", res_full, 0);
        for (int i = 48; i < 64; i++) wr(16'h1000 + 16'(i));
        @(negedge clk);
        chk("full_64", res_full, 1);
        chk("ovf_64", overflow, 0);
        chk("lcnt_64", line_count, 4);
        for (int i = 64; i < 80; i++) wr(16'h1000 + 16'(i));
        @(negedge clk);
        chk("ovf_80", overflow, 1);
        chk("lcnt_80", line_count, 4);
        chk("rcnt_80", result_count, 80);
        chk("head_80", line_data[15:0], 16'h1000);

        // Push and pop together at full.
        pulse_en();
        for (int i = 0; i < 15; i++) wr(16'h2000 + 16'(i));
        @(negedge clk);
        chk("full_pre_pp", res_full, 1);
        ready = 1'b1;
        wr(16'h200F);
        ready = 1'b0;
        @(negedge clk);
        chk("pp_full", res_full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_lcnt", line_count, 1);
        chk("pp_head", line_data[15:0], 16'h1010);
        ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("drained", line_valid, 0);

        // 16th write together with tile_done, then a lone tile_done.
        pulse_en();
        for (int i = 0; i < 15; i++) wr(16'h5000 + 16'(i));
        r_valid   = 1'b1;
        r_data    = 16'h500F;
        tile_done = 1'b1;
        step();
        r_valid   = 1'b0;
        tile_done = 1'b0;
        @(negedge clk);
        chk("cd_valid", line_valid, 1);
        chk("cd_last", line_last, 1);
        chk("cd_lane15", line_data[255:240], 16'h500F);
        chk("cd_lcnt", line_count, 1);
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        @(negedge clk);
        chk("done_alone_valid", line_valid, 0);
        chk("done_alone_lcnt", line_count, 1);

        // Asynchronous reset with two lines queued and a partial line.
        ready = 1'b0;
        pulse_en();
        for (int i = 0; i < 39; i++) wr(16'h3000 + 16'(i));
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 16; i++) wr(16'h4000 + 16'(i));
        @(negedge clk);
        chk("post_rst_valid", line_valid, 1);
        chk("post_rst_lane0", line_data[15:0], 16'h4000);
        chk("post_rst_lcnt", line_count, 1);
        chk("post_rst_rcnt", result_count, 16);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
